layer0_input_quantizer: RTL and testbench
=========================================

Name: layer0_input_quantizer

Overview:
- Streaming front end that feeds the first LogicNets neuron layer.
- Accepts raw signed feature words one per beat over a valid/ready stream.
- Quantizes each word to Q_BITS with a uniform offset/shift/clamp quantizer and packs NUM_FEATURES codes into one flat vector.
- Presents the vector to layer0 over a valid/ready handshake; the vector is held stable until consumed.

Parameters:
- NUM_FEATURES, 16, features per frame (valid range ≥2).
- RAW_W, 16, raw feature width, two's complement.
- Q_BITS, 2, code width per feature; layer0 neuron input granularity.
- OFFSET, 0, signed RAW_W-bit value subtracted before scaling.
- SHIFT, 8, right-shift applied after the offset (0..RAW_W).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  raw feature beat valid.
- s_ready  output  1  block can accept a beat.
- s_data  input  RAW_W  raw feature, signed.
- s_last  input  1  marks final feature of a frame.
- m_valid  output  1  packed vector valid.
- m_ready  input  1  layer0 consumes the vector.
- m_data  output  NUM_FEATURES*Q_BITS  packed codes; feature k occupies bits [k*Q_BITS +: Q_BITS].
- frame_err  output  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset is asynchronous on rst_n low. It is released synchronously by design intent; no internal synchronizer.
- Reset values: s_ready=0, m_valid=0, m_data=0, frame_err=0, count=0, state=FILL.
- First cycle after reset: s_ready=1.
- Quantizer, combinational on s_data:
  - d = sext(s_data) − sext(OFFSET), computed at RAW_W+1 bits.
  - d<0 → code 0.
  - Otherwise u = d>>>SHIFT; u > 2^Q_BITS−1 → code 2^Q_BITS−1; else code = u[Q_BITS−1:0].
- Transfers: a beat transfers when s_valid & s_ready; a vector transfers when m_valid & m_ready.
- State FILL:
  - s_ready=1, m_valid=0.
  - On each beat, the code is written into the slot at index count; count increments.
  - Beat with count==NUM_FEATURES−1 and s_last=1: slot written, count←0, state←HOLD, m_valid=1 from the next cycle.
  - Beat with s_last=1 and count<NUM_FEATURES−1 (short frame): frame_err pulses next cycle, partial slots are discarded, count←0, stays FILL, no output.
  - Beat with count==NUM_FEATURES−1 and s_last=0 (long frame): frame_err pulses next cycle. The block enters DROP; it does not output.
- State DROP:
  - s_ready=1; beats are discarded.
  - A beat with s_last=1 returns to FILL with count=0. No further frame_err for that frame.
- State HOLD:
  - s_ready=0, m_valid=1; m_data is stable and m_valid does not drop until transfer.
  - On vector transfer: next cycle m_valid=0, state=FILL, s_ready=1. There is one bubble cycle between frames.
  - m_data keeps its last value after transfer; only slots are overwritten during the next fill.
- Latency:
  - Last beat accepted at cycle t → m_valid=1 at t+1.
  - Maximum throughput: one frame per NUM_FEATURES+1 cycles when m_ready is held high.
- s_data and s_last are ignored when s_valid=0.
- Asserting rst_n low mid-frame or in HOLD returns all state to reset values immediately; the partial frame is lost.
- frame_err is strictly a single-cycle pulse per malformed frame.

Test Plan:
- Defaults, frame of 16 beats with s_data = 0x0000, 0x0100, 0x02FF, 0x7FFF repeated 4×, s_last on beat 16, m_ready=1 → m_valid at cycle after beat 16, m_data = 0xE4E4_E4E4 (codes 0,1,2,3 per group), m_valid low next cycle.
- Negative/clamp: all beats 0x8000 → m_data = 0x0000_0000; all beats 0x0300 → m_data = 0xFFFF_FFFF.
- Backpressure: m_ready=0 for 10 cycles after a complete frame → m_valid and m_data stable, s_ready=0 throughout; m_ready=1 → transfer, s_ready=1 the following cycle.
- Short frame: s_last on beat 5 → frame_err pulse one cycle, no m_valid; the next correct 16-beat frame is output correctly.
- Long frame: 20 beats, s_last on beat 20 → frame_err pulse after beat 16, no m_valid, s_ready stays 1. The next frame is output correctly.
- Reset mid-frame: rst_n low after beat 8 → s_ready, m_valid, m_data, frame_err are 0 asynchronously. After release, a full frame yields the correct vector with no residue from the aborted one.

Source files
------------

// File: rtl/layer0_input_quantizer.sv
// Streaming front end for the first LogicNets layer: quantizes signed raw
// feature beats to Q_BITS codes, packs a full frame into one vector and hands
// it to layer0 over a valid/ready handshake.
//
// state | meaning
// FILL  | accepting beats, writing codes into slot[count]
// HOLD  | packed vector presented on m_data, waiting for m_ready
// DROP  | overlong frame detected, discarding beats until s_last
module layer0_input_quantizer #(
  parameter int                      NUM_FEATURES = 16,
  parameter int                      RAW_W        = 16,
  parameter int                      Q_BITS       = 2,
  parameter logic signed [RAW_W-1:0] OFFSET       = '0,
  parameter int                      SHIFT        = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [RAW_W-1:0]               s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_FEATURES*Q_BITS-1:0] m_data,
  output logic                           frame_err
);

  localparam int OUT_W = NUM_FEATURES * Q_BITS;
  localparam int CNT_W = $clog2(NUM_FEATURES);
  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(NUM_FEATURES - 1);
  localparam logic signed [RAW_W:0]   CODE_MAX = (RAW_W+1)'((1 << Q_BITS) - 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [OUT_W-1:0]    r_slots;
  logic [OUT_W-1:0]    r_m_data;
  logic                r_s_ready;
  logic                r_m_valid;
  logic                r_frame_err;

  logic signed [RAW_W:0] w_d;
  logic signed [RAW_W:0] w_u;
  logic [Q_BITS-1:0]     w_code;
  logic [OUT_W-1:0]      w_frame;
  logic                  w_beat;
  logic                  w_xfer;

  assign w_beat = s_valid & r_s_ready;
  assign w_xfer = r_m_valid & m_ready;

  // Offset/shift/clamp quantizer; one extra bit keeps the subtraction exact.
  always_comb begin
    w_d = $signed({s_data[RAW_W-1], s_data}) - $signed({OFFSET[RAW_W-1], OFFSET});
    w_u = w_d >>> SHIFT;
    if (w_d < 0) begin
      w_code = '0;
    end else if (w_u > CODE_MAX) begin
      w_code = '1;
    end else begin
      w_code = w_u[Q_BITS-1:0];
    end
  end

  // Slot image including the beat currently on the bus, so the final beat
  // lands in m_data on the same edge that completes the frame.
  always_comb begin
    w_frame = r_slots;
    w_frame[int'(r_count)*Q_BITS +: Q_BITS] = w_code;
  end

  // Frame FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_count     <= '0;
      r_slots     <= '0;
      r_m_data    <= '0;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_FILL: begin
          r_s_ready <= 1'b1;
          if (w_beat) begin
            r_slots <= w_frame;
            if (r_count == LAST_IDX) begin
              r_count <= '0;
              if (s_last) begin
                r_m_data  <= w_frame;
                r_m_valid <= 1'b1;
                r_s_ready <= 1'b0;
                r_state   <= ST_HOLD;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= ST_DROP;
              end
            end else if (s_last) begin
              // Short frame: discard partial slots by restarting the count.
              r_frame_err <= 1'b1;
              r_count     <= '0;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        ST_DROP: begin
          r_s_ready <= 1'b1;
          if (w_beat && s_last) begin
            r_count <= '0;
            r_state <= ST_FILL;
          end
        end
        ST_HOLD: begin
          r_s_ready <= 1'b0;
          if (w_xfer) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= ST_FILL;
          end
        end
        default: begin
          r_state   <= ST_FILL;
          r_count   <= '0;
          r_m_valid <= 1'b0;
          r_s_ready <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_layer0_input_quantizer.sv
// Scoreboard bench for layer0_input_quantizer: a driver issues frames and
// pushes the expected packed vector, a monitor pops on every vector transfer.
module tb_layer0_input_quantizer;

  localparam int NF       = 16;
  localparam int RW       = 16;
  localparam int QB       = 2;
  localparam int OW       = NF * QB;
  localparam int M_OFFSET = 0;
  localparam int M_SHIFT  = 8;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [RW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          frame_err;

  layer0_input_quantizer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [OW-1:0] exp_q[$];
  logic [RW-1:0] fbuf[$];
  logic [OW-1:0] last_vec;
  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int err_exp  = 0;
  int mr_mode  = 2;   // 0 random, 1 hold low, 2 hold high
  bit gaps     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference quantizer in plain integer arithmetic.
  function automatic int quant(input logic [RW-1:0] raw);
    int d;
    d = int'($signed(raw)) - M_OFFSET;
    if (d < 0) return 0;
    d = d / (1 << M_SHIFT);
    if (d > (1 << QB) - 1) return (1 << QB) - 1;
    return d;
  endfunction

  // m_ready driver, updated shortly after each rising edge.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (mr_mode)
        0:       m_ready = ($urandom_range(0, 3) != 0);
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pop on transfer, hold-stability check while stalled.
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic          prev_err  = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_m_valid", m_valid, 1);
        check("hold_m_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_vector", m_valid, 0);
        else check("vector", m_data, exp_q.pop_front());
      end
      if (frame_err) begin
        err_seen++;
        check("frame_err_pulse", prev_err, 0);
      end
      prev_err  = frame_err;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  // Drives n_send beats of an n-beat frame held in fbuf.
  task automatic send_frame(input int n, input int n_send);
    logic [OW-1:0] v;
    if (n_send == n) begin
      if (n == NF) begin
        v = '0;
        for (int k = 0; k < NF; k++) v[k*QB +: QB] = QB'(quant(fbuf[k]));
        exp_q.push_back(v);
        last_vec = v;
      end else begin
        err_exp++;
      end
    end
    for (int i = 0; i < n_send; i++) begin
      int t;
      t = 0;
      if (gaps && $urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          s_valid = 1'b0;
          s_data  = RW'($urandom);
          s_last  = 1'($urandom);
        end
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = fbuf[i];
      s_last  = (i == n - 1);
      while (!s_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t >= 300) check("s_ready_wait", s_ready, 1);
      if (i >= NF) check("drop_s_ready", (t == 0), 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("frame_err_beat", frame_err,
            ((n < NF && i == n - 1) || (n > NF && i == NF - 1)) ? 1 : 0);
      if (n == NF && n_send == n && i == n - 1) check("m_valid_latency", m_valid, 1);
    end
  endtask

  task automatic fill_const(input int n, input logic [RW-1:0] val);
    fbuf.delete();
    for (int i = 0; i < n; i++) fbuf.push_back(val);
  endtask

  task automatic fill_rand(input int n);
    fbuf.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) fbuf.push_back(RW'($urandom));
      else fbuf.push_back(RW'($urandom_range(0, 1279)) - RW'(256));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [RW-1:0] pat[4];
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    last_vec = '0;
    #12;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_cycle_s_ready", s_ready, 1);

    // Default pattern 0,1,2,3 codes per group of four.
    pat[0] = 16'h0000; pat[1] = 16'h0100; pat[2] = 16'h02FF; pat[3] = 16'h7FFF;
    fbuf.delete();
    for (int i = 0; i < NF; i++) fbuf.push_back(pat[i % 4]);
    send_frame(NF, NF);
    check("pattern_model", last_vec, 32'hE4E4_E4E4);
    @(posedge clk);
    #1;
    check("m_valid_drop", m_valid, 0);
    check("s_ready_after_xfer", s_ready, 1);

    // Negative and clamp extremes.
    fill_const(NF, 16'h8000);
    send_frame(NF, NF);
    fill_const(NF, 16'h0300);
    send_frame(NF, NF);
    drain();

    // Backpressure.
    mr_mode = 1;
    @(posedge clk);
    #3;
    fill_rand(NF);
    send_frame(NF, NF);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data", m_data, last_vec);
      check("bp_s_ready", s_ready, 0);
    end
    mr_mode = 2;
    @(posedge clk);
    #3;
    @(posedge clk);
    #1;
    check("bp_release_m_valid", m_valid, 0);
    check("bp_release_s_ready", s_ready, 1);

    // Short frame followed by a good frame.
    fill_rand(5);
    send_frame(5, 5);
    fill_rand(NF);
    send_frame(NF, NF);

    // Long frame followed by a good frame.
    fill_rand(20);
    send_frame(20, 20);
    fill_rand(NF);
    send_frame(NF, NF);

    // Reset mid-frame with a known non-zero vector on m_data.
    fill_const(NF, 16'h0100);
    send_frame(NF, NF);
    drain();
    fill_rand(NF);
    send_frame(NF, 8);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_s_ready", s_ready, 0);
    check("async_rst_m_valid", m_valid, 0);
    check("async_rst_m_data", m_data, 0);
    check("async_rst_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", s_ready, 1);
    fill_rand(NF);
    send_frame(NF, NF);
    drain();

    // Randomized traffic with gaps, backpressure and malformed frames.
    gaps    = 1;
    mr_mode = 0;
    for (int f = 0; f < 40; f++) begin
      int r;
      int n;
      r = $urandom_range(0, 9);
      if (r == 0)      n = $urandom_range(1, NF - 1);
      else if (r == 1) n = $urandom_range(NF + 1, NF + 8);
      else             n = NF;
      fill_rand(n);
      send_frame(n, n);
    end
    drain();
    repeat (3) @(negedge clk);
    check("frame_err_count", err_seen, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
